bsg_clk_gen_pearl_tag_sequencer: RTL and testbench

- Sequences programming of one clock-generator pearl over its bsg_tag serial interface.
- Accepts a configuration request (oscillator code, downsample value, output select) through a valid/ready handshake.
- Expands each request into an ordered series of bsg_tag packets and emits them bit-serially on tag_data_o, synchronous to clk_i.
- Sits beside the pearl; clk_i also drives the pearl's tag clock input.

---
 rtl/bsg_clk_gen_pearl_tag_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_bsg_clk_gen_pearl_tag_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_clk_gen_pearl_tag_sequencer.sv
`default_nettype none
// ============================================================================
// bsg_clk_gen_pearl_tag_sequencer: turns one pearl config request into bsg_tag packets, bit-serial.
// Rev 1.0
// ============================================================================
module bsg_clk_gen_pearl_tag_sequencer #(
  parameter int tag_els_p      = 1024,
  parameter int tag_lg_width_p = 4,
  parameter int osc_width_p    = 5,
  parameter int ds_width_p     = 8,
  parameter int gap_p          = 4,
  localparam int c_idw = (tag_els_p > 1) ? $clog2(tag_els_p) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [c_idw-1:0]       node_id_offset_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  logic                   sel_only_i,
  input  logic [osc_width_p-1:0] osc_code_i,
  input  logic [ds_width_p-1:0]  ds_val_i,
  input  logic [1:0]             sel_i,
  output logic                   tag_data_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int c_dsw = ds_width_p + 1;
  localparam int c_pw0 = (osc_width_p > c_dsw) ? osc_width_p : c_dsw;
  localparam int c_pw  = (c_pw0 > 2) ? c_pw0 : 2;
  localparam int c_sw0 = (c_idw > tag_lg_width_p) ? c_idw : tag_lg_width_p;
  localparam int c_sw  = (c_sw0 > c_pw) ? c_sw0 : c_pw;
  localparam int c_cm  = (c_sw > gap_p) ? c_sw : gap_p;
  localparam int c_cw  = $clog2(c_cm) + 1;

  if (osc_width_p >= (1 << tag_lg_width_p)) begin : g_osc_len_chk
    $error("osc_width_p does not fit in the tag length field");
  end
  if (c_dsw >= (1 << tag_lg_width_p)) begin : g_ds_len_chk
    $error("ds_width_p+1 does not fit in the tag length field");
  end
  if (gap_p < 1) begin : g_gap_chk
    $error("gap_p must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_ID      = 3'd2,
    S_DNR     = 3'd3,
    S_LEN     = 3'd4,
    S_PAYLOAD = 3'd5,
    S_GAP     = 3'd6
  } state_t;

  state_t                   r_state, w_state_n;
  logic [c_cw-1:0]          r_cnt, w_cnt_n;
  logic [c_sw-1:0]          r_shift, w_shift_n;
  logic [2:0]               r_pkt, w_pkt_n;
  logic                     r_tag, r_done;
  logic                     w_accept, w_tag_n, w_done_n;
  logic [osc_width_p-1:0]   r_osc;
  logic [ds_width_p-1:0]    r_ds;
  logic [1:0]               r_sel;
  logic [c_idw-1:0]         r_offset;
  logic [2:0]               w_idx;
  logic [tag_lg_width_p-1:0] w_len;
  logic [c_pw-1:0]          w_pay;
  logic [c_idw-1:0]         w_node;

  // Packet table: local node index, payload length and payload for each step
  always_comb begin
    w_idx = 3'd0;
    w_len = tag_lg_width_p'(1);
    w_pay = '0;
    case (r_pkt)
      3'd0: w_pay = c_pw'(1);
      3'd1: begin
        w_idx = 3'd1;
        w_len = tag_lg_width_p'(osc_width_p);
        w_pay = c_pw'(r_osc);
      end
      3'd2: begin
        w_idx = 3'd2;
        w_pay = c_pw'(1);
      end
      3'd3: w_idx = 3'd2;
      3'd4: w_idx = 3'd0;
      3'd5: begin
        w_idx = 3'd3;
        w_len = tag_lg_width_p'(c_dsw);
        w_pay = c_pw'({r_ds, 1'b1});
      end
      3'd6: begin
        w_idx = 3'd3;
        w_len = tag_lg_width_p'(c_dsw);
        w_pay = c_pw'({r_ds, 1'b0});
      end
      default: begin
        w_idx = 3'd4;
        w_len = tag_lg_width_p'(2);
        w_pay = c_pw'(r_sel);
      end
    endcase
  end

  assign w_node = r_offset + c_idw'(w_idx);

  // Each field is loaded into the shift register; bit 0 is the bit on the wire
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_shift_n = r_shift;
    w_pkt_n   = r_pkt;
    w_accept  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (v_i) begin
          w_accept  = 1'b1;
          w_state_n = S_START;
          w_shift_n = c_sw'(1);
          w_pkt_n   = sel_only_i ? 3'd7 : 3'd0;
        end
      end
      S_START: begin
        w_state_n = S_ID;
        w_shift_n = c_sw'(w_node);
        w_cnt_n   = c_cw'(c_idw - 1);
      end
      S_ID: begin
        if (r_cnt == '0) begin
          w_state_n = S_DNR;
          w_shift_n = c_sw'(1);
        end else begin
          w_shift_n = r_shift >> 1;
          w_cnt_n   = r_cnt - c_cw'(1);
        end
      end
      S_DNR: begin
        w_state_n = S_LEN;
        w_shift_n = c_sw'(w_len);
        w_cnt_n   = c_cw'(tag_lg_width_p - 1);
      end
      S_LEN: begin
        if (r_cnt == '0) begin
          w_state_n = S_PAYLOAD;
          w_shift_n = c_sw'(w_pay);
          w_cnt_n   = c_cw'(w_len) - c_cw'(1);
        end else begin
          w_shift_n = r_shift >> 1;
          w_cnt_n   = r_cnt - c_cw'(1);
        end
      end
      S_PAYLOAD: begin
        if (r_cnt == '0) begin
          w_state_n = S_GAP;
          w_shift_n = '0;
          w_cnt_n   = c_cw'(gap_p - 1);
        end else begin
          w_shift_n = r_shift >> 1;
          w_cnt_n   = r_cnt - c_cw'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          if (r_pkt == 3'd7) begin
            w_state_n = S_IDLE;
          end else begin
            w_state_n = S_START;
            w_pkt_n   = r_pkt + 3'd1;
            w_shift_n = c_sw'(1);
          end
        end else begin
          w_cnt_n = r_cnt - c_cw'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign w_tag_n  = (w_state_n != S_IDLE) && (w_state_n != S_GAP) && w_shift_n[0];
  assign w_done_n = (r_state == S_GAP) && (w_state_n == S_IDLE);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_pkt   <= '0;
      r_tag   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_shift <= w_shift_n;
      r_pkt   <= w_pkt_n;
      r_tag   <= w_tag_n;
      r_done  <= w_done_n;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_osc    <= '0;
      r_ds     <= '0;
      r_sel    <= '0;
      r_offset <= '0;
    end else if (w_accept) begin
      r_osc    <= osc_code_i;
      r_ds     <= ds_val_i;
      r_sel    <= sel_i;
      r_offset <= node_id_offset_i;
    end
  end

  assign ready_o    = (r_state == S_IDLE);
  assign busy_o     = (r_state != S_IDLE);
  assign tag_data_o = r_tag;
  assign done_o     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bsg_clk_gen_pearl_tag_sequencer.sv
`default_nettype none
// Bench for bsg_clk_gen_pearl_tag_sequencer: decodes the serial stream back into packets
// and compares against hand-computed packet tables.
module tb_bsg_clk_gen_pearl_tag_sequencer;

  localparam int IDW = 10;
  localparam int LGW = 4;
  localparam int GAP = 4;
  localparam int NV  = 5;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic [9:0] node_id_offset_i = '0;
  logic       v_i = 1'b0;
  logic       ready_o;
  logic       sel_only_i = 1'b0;
  logic [4:0] osc_code_i = '0;
  logic [7:0] ds_val_i = '0;
  logic [1:0] sel_i = '0;
  logic       tag_data_o, busy_o, done_o;

  always #5 clk_i = ~clk_i;

  bsg_clk_gen_pearl_tag_sequencer dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .node_id_offset_i(node_id_offset_i),
    .v_i(v_i), .ready_o(ready_o), .sel_only_i(sel_only_i), .osc_code_i(osc_code_i),
    .ds_val_i(ds_val_i), .sel_i(sel_i), .tag_data_o(tag_data_o), .busy_o(busy_o),
    .done_o(done_o)
  );

  typedef struct {
    bit         so;
    logic [4:0] osc;
    logic [7:0] ds;
    logic [1:0] sel;
    logic [9:0] off;
    int         exp_busy;
  } vec_t;

  typedef struct {
    int id;
    int len;
    int pay;
    int dnr;
  } pkt_t;

  int   n_cmp = 0;
  int   n_fail = 0;
  bit   bits_q[$];
  pkt_t got_q[$];
  pkt_t exp_q[$];
  int   gap_q[$];
  int   lead_z;
  bit   done_seen, idle_bad;
  vec_t vecs[NV];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference packet list: (index, len, payload) per bring-up step
  task automatic build_exp(input vec_t v);
    int idx[8];
    int len[8];
    int pay[8];
    idx = '{0, 1, 2, 2, 0, 3, 3, 4};
    len = '{1, 5, 1, 1, 1, 9, 9, 2};
    pay = '{1, int'(v.osc), 1, 0, 0, int'({v.ds, 1'b1}), int'({v.ds, 1'b0}), int'(v.sel)};
    exp_q.delete();
    for (int k = (v.so ? 7 : 0); k < 8; k++) begin
      pkt_t e;
      e.id  = (int'(v.off) + idx[k]) % 1024;
      e.len = len[k];
      e.pay = pay[k];
      e.dnr = 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic decode();
    int pos;
    int n;
    pos = 0;
    n = bits_q.size();
    got_q.delete();
    gap_q.delete();
    lead_z = 0;
    while (pos < n && bits_q[pos] == 1'b0) begin
      lead_z++;
      pos++;
    end
    while (pos < n) begin
      pkt_t p;
      int   z;
      if (pos + 1 + IDW + 1 + LGW > n) break;
      pos++;
      p.id = 0;
      for (int k = 0; k < IDW; k++) p.id |= int'(bits_q[pos+k]) << k;
      pos += IDW;
      p.dnr = int'(bits_q[pos]);
      pos++;
      p.len = 0;
      for (int k = 0; k < LGW; k++) p.len |= int'(bits_q[pos+k]) << k;
      pos += LGW;
      if (pos + p.len > n) break;
      p.pay = 0;
      for (int k = 0; k < p.len; k++) p.pay |= int'(bits_q[pos+k]) << k;
      pos += p.len;
      got_q.push_back(p);
      z = 0;
      while (pos < n && bits_q[pos] == 1'b0) begin
        z++;
        pos++;
      end
      gap_q.push_back(z);
    end
  endtask

  // Called just after a negedge; acceptance happens on the following posedge
  task automatic start_req(input vec_t v);
    chk("ready_at_req", int'(ready_o), 1);
    sel_only_i       = v.so;
    osc_code_i       = v.osc;
    ds_val_i         = v.ds;
    sel_i            = v.sel;
    node_id_offset_i = v.off;
    v_i              = 1'b1;
  endtask

  task automatic collect(input bit glitch, input bit chain, input vec_t nxt);
    bits_q.delete();
    done_seen = 1'b0;
    idle_bad  = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        done_seen = 1'b1;
        if (tag_data_o !== 1'b0) idle_bad = 1'b1;
        if (chain) begin
          chk("ready_on_done", int'(ready_o), 1);
          start_req(nxt);
        end
        break;
      end
      if (busy_o) bits_q.push_back(tag_data_o);
      else if (tag_data_o !== 1'b0) idle_bad = 1'b1;
      if (i == 0) v_i = 1'b0;
      if (glitch && i == 10) begin
        v_i        = 1'b1;
        osc_code_i = ~osc_code_i;
        sel_i      = ~sel_i;
        ds_val_i   = ~ds_val_i;
        sel_only_i = ~sel_only_i;
      end
      if (glitch && i == 100) v_i = 1'b0;
    end
  endtask

  task automatic check_vec(input string nm, input vec_t v);
    int nbad;
    int m;
    build_exp(v);
    decode();
    chk({nm, "_done_seen"}, int'(done_seen), 1);
    chk({nm, "_idle_tag"}, int'(idle_bad), 0);
    chk({nm, "_busy_cycles"}, bits_q.size(), v.exp_busy);
    chk({nm, "_npkt"}, got_q.size(), exp_q.size());
    chk({nm, "_lead_zeros"}, lead_z, 0);
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < m; k++) begin
      chk($sformatf("%s_p%0d_id", nm, k), got_q[k].id, exp_q[k].id);
      chk($sformatf("%s_p%0d_len", nm, k), got_q[k].len, exp_q[k].len);
      chk($sformatf("%s_p%0d_pay", nm, k), got_q[k].pay, exp_q[k].pay);
      chk($sformatf("%s_p%0d_dnr", nm, k), got_q[k].dnr, 1);
    end
    nbad = 0;
    foreach (gap_q[k]) if (gap_q[k] != GAP) nbad++;
    chk({nm, "_bad_gaps"}, nbad, 0);
  endtask

  initial begin
    int t1;
    int nb;
    vec_t rm;

    // sel_only: 16+2 bits + gap = 22; full: 157 packet bits + 8*4 gap = 189
    vecs[0] = '{1'b1, 5'h00, 8'h00, 2'b10, 10'd16,   22};
    vecs[1] = '{1'b1, 5'h1F, 8'hFF, 2'b01, 10'd0,    22};
    vecs[2] = '{1'b1, 5'h00, 8'h00, 2'b11, 10'd1023, 22};
    vecs[3] = '{1'b0, 5'h13, 8'hA5, 2'b10, 10'd0,    189};
    vecs[4] = '{1'b0, 5'h00, 8'hFF, 2'b00, 10'd1020, 189};
    rm      = '{1'b0, 5'h1F, 8'h00, 2'b01, 10'd0,    189};

    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      chk($sformatf("idle_%0d_tag_ready_busy", i), int'({tag_data_o, ready_o, busy_o}), 3'b010);
    end

    for (int r = 0; r < NV; r++) begin
      start_req(vecs[r]);
      collect(1'b0, 1'b0, vecs[r]);
      check_vec($sformatf("vec%0d", r), vecs[r]);
      @(negedge clk_i);
    end

    // Input changes and v_i while busy must not disturb the running sequence
    start_req(vecs[3]);
    collect(1'b1, 1'b0, vecs[3]);
    check_vec("glitch", vecs[3]);
    nb = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (busy_o !== 1'b0) nb++;
    end
    chk("glitch_no_second_seq", nb, 0);

    // Request on the done cycle; the IDLE/done cycle adds one zero to the gap
    start_req(vecs[0]);
    collect(1'b0, 1'b1, vecs[1]);
    check_vec("b2b_first", vecs[0]);
    t1 = (gap_q.size() > 0) ? gap_q[gap_q.size()-1] : -1;
    collect(1'b0, 1'b0, vecs[1]);
    check_vec("b2b_second", vecs[1]);
    chk("b2b_separation", t1 + 1 + lead_z, GAP + 1);
    @(negedge clk_i);

    // Reset during P1 payload (stream bits 37..41)
    start_req(rm);
    for (int i = 0; i <= 38; i++) begin
      @(negedge clk_i);
      if (i == 0) v_i = 1'b0;
    end
    chk("pre_reset_tag", int'(tag_data_o), 1);
    reset_n_i = 1'b0;
    #1;
    chk("async_reset_tag_busy_done", int'({tag_data_o, busy_o, done_o}), 0);
    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("post_reset_ready_busy", int'({ready_o, busy_o}), 2'b10);
    start_req(vecs[3]);
    collect(1'b0, 1'b0, vecs[3]);
    check_vec("post_reset", vecs[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
